// File: rtl/alu_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ERR_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL = 4'd3;
  localparam logic [OP_W-1:0] OP_DIV = 4'd4;
  localparam logic [OP_W-1:0] OP_MOD = 4'd5;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_OVF     = 2'b01;
  localparam logic [ERR_W-1:0] ERR_DIV0    = 2'b10;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // MUL always iterates; DIV/MOD iterate only with a nonzero divisor.
  function automatic logic needs_core(input logic [OP_W-1:0] op, input logic b_zero);
    needs_core = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_alu_itercore.sv
// Unsigned W-iteration shift-add multiplier / restoring divider on one shared 2*W accumulator.
// The start edge loads the operands and performs the first iteration; done rises after the W-th.
module seq_alu_itercore #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem
);

  localparam int unsigned CW = $clog2(W);

  logic          busy;
  logic          mode_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo, b_q;

  logic          cur_mode;
  logic [W-1:0]  cur_hi, cur_lo, cur_b;
  logic [W:0]    add_sum, mul_base, shl, trial;
  logic [W-1:0]  hi_step, lo_step;

  // One iteration, taken either from the fresh operands (start) or the accumulator.
  always_comb begin
    cur_mode = start ? mode : mode_q;
    cur_hi   = start ? '0 : hi;
    cur_lo   = start ? a : lo;
    cur_b    = start ? b : b_q;

    add_sum  = {1'b0, cur_hi} + {1'b0, cur_b};
    mul_base = cur_lo[0] ? add_sum : {1'b0, cur_hi};
    shl      = {cur_hi, cur_lo[W-1]};
    trial    = shl - {1'b0, cur_b};

    hi_step  = mul_base[W:1];
    lo_step  = {mul_base[0], cur_lo[W-1:1]};
    if (cur_mode) begin
      if (!trial[W]) begin
        hi_step = trial[W-1:0];
        lo_step = {cur_lo[W-2:0], 1'b1};
      end else begin
        hi_step = shl[W-1:0];
        lo_step = {cur_lo[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      b_q    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      done   <= 1'b0;
      mode_q <= mode;
      b_q    <= b;
      cnt    <= CW'(1);
      hi     <= hi_step;
      lo     <= lo_step;
    end else if (busy) begin
      hi  <= hi_step;
      lo  <= lo_step;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(W - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign prod = {hi, lo};
  assign quot = lo;
  assign rem  = hi;

endmodule

// File: rtl/seq_alu.sv
// Clocked signed ALU: single-cycle ADD/SUB, iterative MUL/DIV/MOD, valid/ready on both sides.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [OP_W-1:0]  Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   Result,
  output logic [ERR_W-1:0] Error
);

  localparam int unsigned W2 = 2 * W;

  state_t            state, state_nxt;
  logic              accept, b_zero, use_core, core_start, core_mode;
  logic [W-1:0]      mag_a, mag_b, sum, diff;
  logic [W2-1:0]     direct_res, core_res;
  logic [ERR_W-1:0]  direct_err, core_err;

  logic [OP_W-1:0]   op_q;
  logic              sa_q, sb_q, neg_q;

  logic              core_done;
  logic [W2-1:0]     prod, prod_s;
  logic [W-1:0]      quot, rem, quot_s, rem_s;

  always_comb begin
    accept     = in_valid && in_ready;
    b_zero     = (B == '0);
    use_core   = needs_core(Op, b_zero);
    core_start = accept && use_core;
    core_mode  = (Op != OP_MUL);
    mag_a      = A[W-1] ? W'(-A) : A;
    mag_b      = B[W-1] ? W'(-B) : B;
    sum        = A + B;
    diff       = A - B;
  end

  seq_alu_itercore #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (core_start),
    .mode  (core_mode),
    .a     (mag_a),
    .b     (mag_b),
    .done  (core_done),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  // Results that are known on the acceptance edge.
  always_comb begin
    direct_res = '0;
    direct_err = ERR_ILLEGAL;
    case (Op)
      OP_ADD: begin
        direct_res = {{W{sum[W-1]}}, sum};
        direct_err = {1'b0, (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1])};
      end
      OP_SUB: begin
        direct_res = {{W{diff[W-1]}}, diff};
        direct_err = {1'b0, (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1])};
      end
      OP_MUL:         direct_err = ERR_NONE;
      OP_DIV, OP_MOD: direct_err = ERR_DIV0;
      default:        direct_err = ERR_ILLEGAL;
    endcase
  end

  // Re-apply signs to the unsigned core outputs; MIN/-1 surfaces as a positive quotient with the top bit set.
  always_comb begin
    neg_q    = sa_q ^ sb_q;
    prod_s   = neg_q ? W2'(-prod) : prod;
    quot_s   = neg_q ? W'(-quot) : quot;
    rem_s    = sa_q ? W'(-rem) : rem;
    core_res = {{W{rem_s[W-1]}}, rem_s};
    core_err = ERR_NONE;
    case (op_q)
      OP_MUL: core_res = prod_s;
      OP_DIV: begin
        core_res = {{W{quot_s[W-1]}}, quot_s};
        core_err = {1'b0, !neg_q && quot[W-1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = use_core ? BUSY : DONE;
      BUSY:    if (core_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      Error     <= ERR_NONE;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        op_q <= Op;
        sa_q <= A[W-1];
        sb_q <= B[W-1];
        if (!use_core) begin
          Result <= direct_res;
          Error  <= direct_err;
        end
      end else if ((state == BUSY) && core_done) begin
        Result <= core_res;
        Error  <= core_err;
      end
    end
  end

endmodule
